if_stage_v: RTL
===============

IF_STAGE_V -- requirements
Module: if_stage_v

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0): bubble instruction placed in IF/ID.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stall  input  1  load-use stall from hazard detection unit; hold PC and IF/ID.
REQ-006 flush  input  1  branch/jump taken, resolved downstream; redirect PC, bubble IF/ID.
REQ-007 branch_target  input  32  redirect address, valid when flush=1.
REQ-008 imem_addr  output  32  instruction memory address, combinational copy of PC.
REQ-009 imem_rdata  input  32  instruction word, combinational read of imem_addr.
REQ-010 ifid_pc  output  32  registered PC of instruction held in IF/ID.
REQ-011 ifid_instr  output  32  registered instruction for decode.
REQ-012 ifid_valid  output  1  1 = IF/ID holds a real fetched instruction, 0 = bubble.
REQ-013 stall_cnt  output  32  perf counter of stalled cycles (see Configuration).
REQ-014 flush_cnt  output  32  perf counter of flush cycles (see Configuration).

Function
REQ-015 Internal state SHALL be pc (32) plus IF/ID register (ifid_pc, ifid_instr, ifid_valid); imem_addr SHALL equal pc with zero latency.
REQ-016 Per-edge priority SHALL be rst > flush > stall > advance.
REQ-017 Advance: pc <= pc+4; ifid_pc <= pc; ifid_instr <= imem_rdata; ifid_valid <= 1.
REQ-018 Stall (flush=0): pc, ifid_pc, ifid_instr, ifid_valid SHALL all hold.
REQ-019 Flush: pc <= {branch_target[31:2],2'b00}; ifid_instr <= NOP_INSTR; ifid_valid <= 0; ifid_pc <= 0.
REQ-020 flush and stall asserted together: flush SHALL win, stall ignored that cycle.
REQ-021 PC arithmetic SHALL be modulo 2^32: pc 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-022 branch_target[1:0] SHALL be ignored (forced to zero); no exception raised.
REQ-023 Fetch-to-decode latency SHALL be one cycle: instruction at pc appears on ifid_instr after the next non-stalled, non-flushed edge.
REQ-024 After a flush, the instruction at branch_target SHALL reach IF/ID on the following advancing edge (one bubble cycle total).

Reset
REQ-025 On rst=1 at a rising edge: pc <= RESET_PC; ifid_pc <= 0; ifid_instr <= NOP_INSTR; ifid_valid <= 0; stall_cnt <= 0; flush_cnt <= 0.
REQ-026 rst SHALL override stall and flush in the same cycle; reset mid-stall or mid-flush discards the pending action.

Configuration
REQ-027 Macro IF_PERF_CNT_EN: when defined, stall_cnt SHALL increment on each edge with stall=1, flush=0, rst=0, and flush_cnt on each edge with flush=1, rst=0; both saturate at 32'hFFFF_FFFF.
REQ-028 Without IF_PERF_CNT_EN: stall_cnt and flush_cnt ports SHALL remain present and be driven constant 0; no counter flops synthesized.

Structure
REQ-029 NOP encoding, PC increment (4) and XLEN (32) SHALL live in the shared CPU constants include used by the other pipeline stages.
REQ-030 One sub-module, pc_reg_v (PC register with reset/load/hold/increment), SHALL be instantiated; IF/ID register and counters SHALL stay in if_stage_v.

Verification
REQ-031 rst 2 cycles, then release, imem_rdata=32'h0050_0093 -> imem_addr=0 during reset; after first edge ifid_pc=0, ifid_instr=32'h0050_0093, ifid_valid=1, imem_addr=4.
REQ-032 Advance to pc=8, stall=1 for 2 cycles -> imem_addr stays 8, IF/ID unchanged 2 cycles, stall_cnt=2 (macro on) / 0 (macro off).
REQ-033 flush=1, branch_target=32'h0000_0103 -> next cycle imem_addr=32'h100, ifid_instr=32'h0000_0013, ifid_valid=0, flush_cnt=1.
REQ-034 flush=1 and stall=1 same cycle, target 32'h40 -> pc=32'h40, IF/ID bubble, stall_cnt unchanged, flush_cnt+1.
REQ-035 Flush to 32'hFFFF_FFFC, advance once -> imem_addr=0, ifid_pc=32'hFFFF_FFFC.
REQ-036 rst=1 asserted together with stall=1 and flush=1 at pc=32'h20 -> pc=RESET_PC, ifid_valid=0, both counters 0.

Source files
------------

// File: rtl/if_stage_v_pkg.sv
// Shared CPU constants for the pipeline stages.
// Holds XLEN, the PC increment and the canonical NOP encoding.
package if_stage_v_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] PC_INC = 32'd4;
  localparam logic [XLEN-1:0] NOP    = 32'h0000_0013;
  localparam logic [XLEN-1:0] ZERO   = '0;
  localparam logic [XLEN-1:0] SAT    = '1;

  function automatic logic [XLEN-1:0] align4(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_v_if.sv
// Instruction memory bus between the fetch stage and imem.
// The fetch stage is master, the memory answers combinationally.
interface if_stage_v_if
  import if_stage_v_pkg::*;
;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_addr,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    output imem_rdata
  );

endinterface

// File: rtl/pc_reg_v.sv
// Program counter register.
// Priority: rst > load > hold > increment (wraps modulo 2^32).
module pc_reg_v
  import if_stage_v_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            hold,
  input  logic [XLEN-1:0] load_val,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (!hold) begin
      pc <= pc + PC_INC;
    end
  end

endmodule

// File: rtl/if_stage_v.sv
// Instruction fetch stage: PC, IF/ID register, optional perf counters.
// Define IF_PERF_CNT_EN to build the stall/flush counters.
module if_stage_v
  import if_stage_v_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [XLEN-1:0]   branch_target,
  if_stage_v_if.master      bus,
  output logic [XLEN-1:0]   ifid_pc,
  output logic [XLEN-1:0]   ifid_instr,
  output logic              ifid_valid,
  output logic [XLEN-1:0]   stall_cnt,
  output logic [XLEN-1:0]   flush_cnt
);

  logic [XLEN-1:0] pc;

  pc_reg_v #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .load     (flush),
    .hold     (stall),
    .load_val (align4(branch_target)),
    .pc       (pc)
  );

  assign bus.imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_pc    <= ZERO;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else if (flush) begin
      ifid_pc    <= ZERO;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else if (!stall) begin
      ifid_pc    <= pc;
      ifid_instr <= bus.imem_rdata;
      ifid_valid <= 1'b1;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= ZERO;
      flush_cnt <= ZERO;
    end else begin
      if (flush && flush_cnt != SAT) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
      // stall only counts when flush does not override it
      if (stall && !flush && stall_cnt != SAT) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end
`else
  assign stall_cnt = ZERO;
  assign flush_cnt = ZERO;
`endif

endmodule
